// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register,
// redirect handling, halt FSM and fetched-instruction counter.
module if_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          NPC_OP_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic [31:0]              id_pc4,
  input  logic [15:0]              id_imm16,
  input  logic [25:0]              id_target26,
  input  logic                     stall,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              if_id_instr,
  output logic [31:0]              if_id_pc4,
  output logic                     if_id_valid,
  output logic [31:0]              pc,
  output logic                     halted,
  output logic [31:0]              fetch_count
);

  localparam logic [NPC_OP_LENGTH-1:0] NPC_JUMP   = NPC_OP_LENGTH'(1);
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OFFSET = NPC_OP_LENGTH'(2);
  localparam logic [NPC_OP_LENGTH-1:0] NPC_HALT   = NPC_OP_LENGTH'(3);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_NOP = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc4;
  logic [31:0] jump_pc;
  logic [31:0] br_pc;
  logic        is_jump;
  logic        is_offset;
  logic        is_halt;

  assign pc4       = pc_q + 32'd4;
  assign jump_pc   = {id_pc4[31:28], id_target26, 2'b00};
  assign br_pc     = id_pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign is_jump   = (npc_op == NPC_JUMP);
  assign is_offset = (npc_op == NPC_OFFSET);
  assign is_halt   = (npc_op == NPC_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          unique case (1'b1)
            is_jump: begin
              pc_d    = jump_pc;
              if_id_d = IF_ID_NOP;
            end
            is_offset: begin
              pc_d    = br_pc;
              if_id_d = IF_ID_NOP;
            end
            is_halt: begin
              if_id_d = IF_ID_NOP;
              state_d = HALTED;
            end
            default: begin
              pc_d    = pc4;
              if_id_d = '{instr: imem_rdata, pc4: pc4, valid: 1'b1};
              cnt_d   = cnt_q + 32'd1;
            end
          endcase
        end
      end
      HALTED: if_id_d = IF_ID_NOP;
      default: begin
        state_d = RUN;
        if_id_d = IF_ID_NOP;
      end
    endcase
    // Keep the PC word-aligned regardless of decode inputs.
    pc_d[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      if_id_q <= IF_ID_NOP;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule
